id_ex_stage: RTL

ID/EX pipeline stage that sits directly downstream of the register file. It captures `busX`/`busY`, the immediate, register specifiers and decoded control for the instruction leaving ID, and presents ALU-ready operands to EX. It detects hazards and raises `stall` to hold PC and IF/ID. It resolves RAW dependences from the EX/MEM and MEM/WB stages by operand forwarding, which is selectable at compile time.

---
 rtl/ca_pipe_pkg.sv | 50 +++++
 rtl/fwd_unit.sv | 31 +++
 rtl/id_ex_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ca_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ca_pipe_pkg
// Purpose  : Shared pipeline definitions for the ID/EX stage: control bundle
//            width and bit positions, the bubble control value, the operand
//            forwarding select encoding and the select-resolution helper.
// Revision : 1.0 - initial release
// ============================================================================
package ca_pipe_pkg;

  // Control bundle: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[3:0]}
  localparam int CTRL_W         = 10;
  localparam int CTRL_REGWRITE  = 9;
  localparam int CTRL_MEMREAD   = 8;
  localparam int CTRL_MEMWRITE  = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_REGDST    = 4;
  localparam int CTRL_ALUOP_MSB = 3;
  localparam int CTRL_ALUOP_LSB = 0;

  // A bubble carries no side effects: every control bit is clear.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // The younger producer (EX/MEM) wins over MEM/WB; $0 is never a producer.
  function automatic fwd_sel_e fwd_pick(
    input logic [4:0] src,
    input logic       mem_we,
    input logic [4:0] mem_rw,
    input logic       wb_we,
    input logic [4:0] wb_rw
  );
    fwd_sel_e sel;
    sel = FWD_REG;
    if (mem_we && (mem_rw != 5'd0) && (mem_rw == src)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rw != 5'd0) && (wb_rw == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_unit
// Purpose  : Chooses the operand source for the EX-stage rs and rt paths
//            from the EX/MEM and MEM/WB producers.
// Ports    : ex_rs, ex_rt            - source specifiers held in ID/EX
//            mem_RegWrite, mem_RW    - EX/MEM producer
//            wb_WEN, wb_RW           - MEM/WB producer
//            sel_a, sel_b            - forwarding selects for rs / rt
// Revision : 1.0 - initial release
// ============================================================================
module fwd_unit
  import ca_pipe_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       mem_RegWrite,
  input  logic [4:0] mem_RW,
  input  logic       wb_WEN,
  input  logic [4:0] wb_RW,
  output fwd_sel_e   sel_a,
  output fwd_sel_e   sel_b
);

  always_comb begin
    sel_a = fwd_pick(ex_rs, mem_RegWrite, mem_RW, wb_WEN, wb_RW);
    sel_b = fwd_pick(ex_rt, mem_RegWrite, mem_RW, wb_WEN, wb_RW);
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with hazard detection and optional
//            operand forwarding. Captures the instruction leaving ID and
//            presents ALU-ready operands to EX; raises stall to hold PC and
//            IF/ID.
// Config   : ID_EX_FWD_EN - when defined, EX/MEM and MEM/WB results are
//            forwarded and only load-use stalls. When undefined, operands
//            come straight from the captured bus values and any RAW
//            dependence on EX or MEM stalls.
// Ports    : Clk, rst                - clock, synchronous active-high reset
//            id_*                    - instruction in ID (valid, buses, imm,
//                                      specifiers, control)
//            flush                   - kill the ID instruction
//            mem_RegWrite/RW/result  - EX/MEM producer
//            wb_WEN/RW/busW          - MEM/WB producer
//            stall                   - hold PC and IF/ID
//            ex_*                    - EX slot outputs
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import ca_pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = CTRL_W
) (
  input  logic          Clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [DW-1:0] id_busX,
  input  logic [DW-1:0] id_busY,
  input  logic [15:0]   id_imm,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic [CW-1:0] id_ctrl,
  input  logic          flush,
  input  logic          mem_RegWrite,
  input  logic [4:0]    mem_RW,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_WEN,
  input  logic [4:0]    wb_RW,
  input  logic [DW-1:0] wb_busW,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_opA,
  output logic [DW-1:0] ex_opB,
  output logic [DW-1:0] ex_storeData,
  output logic [4:0]    ex_RW,
  output logic [CW-1:0] ex_ctrl
);

  logic          valid_q;
  logic [DW-1:0] busx_q;
  logic [DW-1:0] busy_q;
  logic [DW-1:0] imm_q;
  logic [4:0]    rs_q;
  logic [4:0]    rt_q;
  logic [4:0]    rw_q;
  logic [CW-1:0] ctrl_q;

  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;
  logic          load_use;
  logic          raw_hzd;

  // A load's data is not available until it reaches WB, so a consumer
  // directly behind it must wait one cycle even with forwarding.
  assign load_use = id_valid && valid_q && ctrl_q[CTRL_MEMREAD] && (rt_q != 5'd0) &&
                    ((rt_q == id_rs) || (rt_q == id_rt));

`ifdef ID_EX_FWD_EN
  fwd_sel_e sel_a;
  fwd_sel_e sel_b;

  fwd_unit u_fwd (
    .ex_rs        (rs_q),
    .ex_rt        (rt_q),
    .mem_RegWrite (mem_RegWrite),
    .mem_RW       (mem_RW),
    .wb_WEN       (wb_WEN),
    .wb_RW        (wb_RW),
    .sel_a        (sel_a),
    .sel_b        (sel_b)
  );

  always_comb begin
    fwd_a = busx_q;
    fwd_b = busy_q;
    case (sel_a)
      FWD_MEM: fwd_a = mem_result;
      FWD_WB:  fwd_a = wb_busW;
      default: fwd_a = busx_q;
    endcase
    case (sel_b)
      FWD_MEM: fwd_b = mem_result;
      FWD_WB:  fwd_b = wb_busW;
      default: fwd_b = busy_q;
    endcase
  end

  assign raw_hzd = 1'b0;
`else
  logic ex_hit;
  logic mem_hit;
  logic unused_inputs;

  assign fwd_a = busx_q;
  assign fwd_b = busy_q;

  // Without forwarding the consumer waits until its producer has reached
  // WB, where the register file's internal write-through supplies the value.
  assign ex_hit  = valid_q && ctrl_q[CTRL_REGWRITE] && (rw_q != 5'd0) &&
                   ((rw_q == id_rs) || (rw_q == id_rt));
  assign mem_hit = mem_RegWrite && (mem_RW != 5'd0) &&
                   ((mem_RW == id_rs) || (mem_RW == id_rt));
  assign raw_hzd = id_valid && (ex_hit || mem_hit);

  assign unused_inputs = ^{mem_result, wb_RW, wb_WEN, wb_busW, rs_q};
`endif

  // A squashed instruction must not hold the front end.
  assign stall = !flush && (load_use || raw_hzd);

  // Reset, flush and stall all load the same all-zero image.
  always_ff @(posedge Clk) begin
    if (rst || flush || stall) begin
      valid_q <= 1'b0;
      busx_q  <= '0;
      busy_q  <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rw_q    <= '0;
      ctrl_q  <= CTRL_BUBBLE;
    end else begin
      valid_q <= id_valid;
      busx_q  <= id_busX;
      busy_q  <= id_busY;
      imm_q   <= {{(DW-16){id_imm[15]}}, id_imm};
      rs_q    <= id_rs;
      rt_q    <= id_rt;
      rw_q    <= id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
      ctrl_q  <= id_ctrl;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_opA       = fwd_a;
  assign ex_opB       = ctrl_q[CTRL_ALUSRC] ? imm_q : fwd_b;
  assign ex_storeData = fwd_b;
  assign ex_RW        = rw_q;
  assign ex_ctrl      = ctrl_q;

endmodule
`default_nettype wire
